button_events: RTL and testbench
================================

# button_events

Per-channel button event generator placed directly downstream of the input debouncer. It takes the debouncer's clean, synchronous level outputs and turns each channel into single-cycle event pulses: press, release, long-press and auto-repeat, plus a held level. UI and control logic consume these pulses instead of raw levels.

## Interface
- PORT_WIDTH, 4, number of independent button channels; must match the debouncer width.
- LONG_CLOCKS, 50_000_000, clock cycles from press to long-press event; must be >= 2.
- REPEAT_CLOCKS, 10_000_000, clock cycles between auto-repeat events after long-press; 0 disables repeat.
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- btn_in  input  PORT_WIDTH  debounced button levels, 1 = pressed; already synchronous to clk.
- press_o  output  PORT_WIDTH  1-cycle pulse per channel on press.
- release_o  output  PORT_WIDTH  1-cycle pulse per channel on release.
- long_o  output  PORT_WIDTH  1-cycle pulse when hold reaches LONG_CLOCKS.
- repeat_o  output  PORT_WIDTH  1-cycle pulse every REPEAT_CLOCKS while held past long-press.
- held_o  output  PORT_WIDTH  level, 1 while channel FSM is not IDLE.

## Operation
- Each channel has its own FSM, its own counter, and its own btn_q register. Channels share nothing.
- Counter width: $clog2(max(LONG_CLOCKS, REPEAT_CLOCKS) + 1).
- States:
  - IDLE, cnt = 0.
  - PRESS: pressed, long-press not yet reached.
  - HELD: long-press reached.
- IDLE: btn_in = 1 and btn_q = 0 -> PRESS, cnt <= 0, press_o <= 1.
- PRESS, btn_in = 1:
  - cnt == LONG_CLOCKS-1 -> HELD, cnt <= 0, long_o <= 1.
  - otherwise cnt <= cnt+1.
- HELD, btn_in = 1, REPEAT_CLOCKS != 0:
  - cnt == REPEAT_CLOCKS-1 -> cnt <= 0, repeat_o <= 1.
  - otherwise cnt <= cnt+1.
- HELD, btn_in = 1, REPEAT_CLOCKS == 0: cnt holds 0; repeat_o is never asserted.
- PRESS or HELD, btn_in = 0 -> IDLE, cnt <= 0, release_o <= 1. Release takes priority on the same edge: no long_o or repeat_o is issued on that edge.
- btn_q <= btn_in every cycle. Press requires a rising level (btn_q = 0), so a level held through IDLE never re-triggers.
- All pulse outputs are registered and default to 0 every cycle unless set as above.
- held_o is registered and equals (next state != IDLE).
- Event order per press: press_o, optional long_o, zero or more repeat_o, release_o. Pulses on one channel never overlap.

## Timing
- Reset (rst_n = 0, asynchronous): state IDLE, cnt 0, btn_q 0, and press_o, release_o, long_o, repeat_o, held_o all 0.
- Latency: the edge that first samples btn_in = 1 sets press_o and held_o high, so both are visible the following cycle. Input to pulse is 1 cycle.
- long_o asserts exactly LONG_CLOCKS cycles after press_o when btn_in stays 1.
- First repeat_o asserts REPEAT_CLOCKS cycles after long_o; subsequent repeat_o pulses are REPEAT_CLOCKS apart.
- release_o asserts 1 cycle after the first sampled btn_in = 0. held_o falls in the same cycle release_o rises.
- Minimum press: btn_in high for 1 cycle gives press_o in cycle n+1 and release_o in cycle n+2.
- Reset de-asserted while btn_in = 1: btn_q = 0, so a press_o is generated on the first active edge. This is intended.
- Reset asserted mid-hold: all outputs clear immediately. No release_o is emitted for the interrupted press.
- Counter never wraps past its terminal value; the terminal compare always resets it to 0.

## Test plan
Bench overrides: LONG_CLOCKS = 8, REPEAT_CLOCKS = 4, PORT_WIDTH = 4.
- Short press: btn_in[0] = 1 for 3 cycles, then 0 -> press_o[0] pulse at t+1, release_o[0] pulse at t+4, held_o[0] high t+1..t+3, no long_o or repeat_o.
- Long hold: btn_in[1] = 1 for 20 cycles -> press_o at t+1, long_o at t+9, repeat_o at t+13 and t+17, release_o at t+21.
- Boundary release: btn_in[2] = 1 for exactly 8 cycles -> press_o at t+1, release_o at t+9, no long_o. Release wins on the terminal edge.
- Simultaneous channels: btn_in = 4'b1111 on one edge -> press_o = 4'b1111 for one cycle. Then drop bit 3 only -> release_o = 4'b1000, other channels continue.
- Reset mid-hold: hold btn_in[0] for 10 cycles, pull rst_n low asynchronously between edges -> all outputs 0 immediately. Release rst_n with btn_in[0] = 1 -> press_o[0] on the first active edge.
- Repeat disabled (REPEAT_CLOCKS = 0): hold for 30 cycles -> exactly one long_o, zero repeat_o, one release_o.

Source files
------------

// File: rtl/button_events.sv
// Per-channel button event generator: turns debounced levels into press, release,
// long-press and auto-repeat pulses plus a held level. Channels are fully independent.
module button_events #(
  parameter int PORT_WIDTH    = 4,
  parameter int LONG_CLOCKS   = 50_000_000,
  parameter int REPEAT_CLOCKS = 10_000_000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [PORT_WIDTH-1:0] btn_in,
  output logic [PORT_WIDTH-1:0] press_o,
  output logic [PORT_WIDTH-1:0] release_o,
  output logic [PORT_WIDTH-1:0] long_o,
  output logic [PORT_WIDTH-1:0] repeat_o,
  output logic [PORT_WIDTH-1:0] held_o
);

  localparam int MAX_CLOCKS = (LONG_CLOCKS > REPEAT_CLOCKS) ? LONG_CLOCKS : REPEAT_CLOCKS;
  localparam int CW         = $clog2(MAX_CLOCKS + 1);
  localparam bit REPEAT_EN  = (REPEAT_CLOCKS != 0);

  localparam logic [CW-1:0] LONG_TERM   = CW'(LONG_CLOCKS - 1);
  localparam logic [CW-1:0] REPEAT_TERM = REPEAT_EN ? CW'(REPEAT_CLOCKS - 1) : '0;
  localparam logic [CW-1:0] CNT_ONE     = CW'(1);

  // IDLE: released; PRESS: pressed, long-press pending; HELD: long-press reached.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    HELD  = 2'd2
  } state_t;

  for (genvar i = 0; i < PORT_WIDTH; i++) begin : g_ch
    // state_q is the per-channel FSM state, reachable hierarchically as g_ch[i].state_q.
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          btn_q;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          long_q, long_d;
    logic          repeat_q, repeat_d;
    logic          held_q, held_d;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q   <= IDLE;
        cnt_q     <= '0;
        btn_q     <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;
        repeat_q  <= 1'b0;
        held_q    <= 1'b0;
      end else begin
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        btn_q     <= btn_in[i];
        press_q   <= press_d;
        release_q <= release_d;
        long_q    <= long_d;
        repeat_q  <= repeat_d;
        held_q    <= held_d;
      end
    end

    // Release is checked first in PRESS and HELD so it wins over a terminal count.
    always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      long_d    = 1'b0;
      repeat_d  = 1'b0;
      case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (btn_in[i] && !btn_q) begin
            state_d = PRESS;
            press_d = 1'b1;
          end
        end
        PRESS: begin
          if (!btn_in[i]) begin
            state_d   = IDLE;
            cnt_d     = '0;
            release_d = 1'b1;
          end else if (cnt_q == LONG_TERM) begin
            state_d = HELD;
            cnt_d   = '0;
            long_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        HELD: begin
          if (!btn_in[i]) begin
            state_d   = IDLE;
            cnt_d     = '0;
            release_d = 1'b1;
          end else if (!REPEAT_EN) begin
            cnt_d = '0;
          end else if (cnt_q == REPEAT_TERM) begin
            cnt_d    = '0;
            repeat_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
      held_d = (state_d != IDLE);
    end

    assign press_o[i]   = press_q;
    assign release_o[i] = release_q;
    assign long_o[i]    = long_q;
    assign repeat_o[i]  = repeat_q;
    assign held_o[i]    = held_q;
  end

endmodule

// File: tb/tb_button_events.sv
// Directed bench for button_events: one instance with repeat enabled, one with repeat
// disabled; outputs sampled on the falling edge, inputs changed on the falling edge.
module tb_button_events;

  logic       clk;
  logic       rst_n;
  logic [3:0] btn_in;
  logic [3:0] press_o, release_o, long_o, repeat_o, held_o;
  logic [3:0] nr_btn_in;
  logic [3:0] nr_press_o, nr_release_o, nr_long_o, nr_repeat_o, nr_held_o;

  int checks = 0;
  int errors = 0;

  button_events #(.PORT_WIDTH(4), .LONG_CLOCKS(8), .REPEAT_CLOCKS(4)) dut (
    .clk(clk), .rst_n(rst_n), .btn_in(btn_in),
    .press_o(press_o), .release_o(release_o), .long_o(long_o),
    .repeat_o(repeat_o), .held_o(held_o)
  );

  button_events #(.PORT_WIDTH(4), .LONG_CLOCKS(8), .REPEAT_CLOCKS(0)) dut_norep (
    .clk(clk), .rst_n(rst_n), .btn_in(nr_btn_in),
    .press_o(nr_press_o), .release_o(nr_release_o), .long_o(nr_long_o),
    .repeat_o(nr_repeat_o), .held_o(nr_held_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] p, input logic [3:0] r,
                           input logic [3:0] l, input logic [3:0] rp, input logic [3:0] h);
    check({tag, " press"},   press_o,   p);
    check({tag, " release"}, release_o, r);
    check({tag, " long"},    long_o,    l);
    check({tag, " repeat"},  repeat_o,  rp);
    check({tag, " held"},    held_o,    h);
  endtask

  // Drive one channel high for 'hold' edges and compare every cycle against the
  // hand-computed event cycles (0 means the event must not occur).
  task automatic watch(input string name, input bit sel, input int ch, input int hold,
                       input int ncyc, input int press_at, input int long_at,
                       input int rep_first, input int rep_period, input int rel_at);
    logic [3:0] bit_ch;
    logic [3:0] e_p, e_r, e_l, e_rp, e_h;
    bit_ch = 4'b0001 << ch;
    if (sel) nr_btn_in = bit_ch; else btn_in = bit_ch;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      e_p  = (c == press_at) ? bit_ch : 4'b0000;
      e_r  = (c == rel_at)   ? bit_ch : 4'b0000;
      e_l  = (long_at != 0 && c == long_at) ? bit_ch : 4'b0000;
      e_rp = (rep_period != 0 && c >= rep_first && c < rel_at &&
              ((c - rep_first) % rep_period) == 0) ? bit_ch : 4'b0000;
      e_h  = (c >= press_at && c < rel_at) ? bit_ch : 4'b0000;
      check($sformatf("%s c%0d press", name, c),   sel ? nr_press_o   : press_o,   e_p);
      check($sformatf("%s c%0d release", name, c), sel ? nr_release_o : release_o, e_r);
      check($sformatf("%s c%0d long", name, c),    sel ? nr_long_o    : long_o,    e_l);
      check($sformatf("%s c%0d repeat", name, c),  sel ? nr_repeat_o  : repeat_o,  e_rp);
      check($sformatf("%s c%0d held", name, c),    sel ? nr_held_o    : held_o,    e_h);
      if (c == hold) begin
        if (sel) nr_btn_in = 4'b0000; else btn_in = 4'b0000;
      end
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    btn_in    = 4'b0000;
    nr_btn_in = 4'b0000;
    #1;
    check_all("reset", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_all("idle", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

    // short press, long hold with repeats, release on the long-press terminal edge
    watch("short",    1'b0, 0, 3,  6,  1, 0, 0,  0, 4);
    watch("longhold", 1'b0, 1, 20, 23, 1, 9, 13, 4, 21);
    watch("boundary", 1'b0, 2, 8,  11, 1, 0, 0,  0, 9);

    // simultaneous press on all channels, drop channel 3 early
    btn_in = 4'b1111;
    @(negedge clk);
    check_all("simul c1", 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b1111);
    @(negedge clk);
    check_all("simul c2", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1111);
    btn_in = 4'b0111;
    @(negedge clk);
    check_all("simul c3", 4'b0000, 4'b1000, 4'b0000, 4'b0000, 4'b0111);
    for (int c = 4; c <= 8; c++) begin
      @(negedge clk);
      check_all($sformatf("simul c%0d", c), 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0111);
    end
    @(negedge clk);
    check_all("simul c9", 4'b0000, 4'b0000, 4'b0111, 4'b0000, 4'b0111);
    btn_in = 4'b0000;
    @(negedge clk);
    check_all("simul c10", 4'b0000, 4'b0111, 4'b0000, 4'b0000, 4'b0000);
    @(negedge clk);
    check_all("simul c11", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

    // reset asserted mid-hold, released with the button still down
    btn_in = 4'b0001;
    repeat (10) @(negedge clk);
    check_all("rsthold c10", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001);
    #2;
    rst_n = 1'b0;
    #1;
    check_all("rst async", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    @(posedge clk);
    #1;
    check_all("rst held low", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_all("rst release c1", 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0001);
    btn_in = 4'b0000;
    @(negedge clk);
    check_all("rst release c2", 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
    @(negedge clk);
    check_all("rst release c3", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

    // repeat disabled: one long, no repeats, one release
    watch("norep", 1'b1, 0, 30, 33, 1, 9, 0, 0, 31);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
